timer_setting_ctrl: RTL and testbench
=====================================

Name: timer_setting_ctrl

Overview:
- Control stage directly upstream of the 6-digit BCD down counter.
- Lets the user edit a HH:MM start value digit by digit using one-cycle button pulses. The pulses are already debounced and one-pulsed upstream.
- Drives the counter's init_value_h1/h0/m1/m0 and en_start[1:0] inputs.
- Sequences the timer through SET, RUN, PAUSE and DONE states from the counter's all-zero indication.

Parameters:
- H1_LIMIT, 4'd5, maximum value of the hour tens digit.
- H0_LIMIT, 4'd9, maximum value of the hour units digit.
- M1_LIMIT, 4'd5, maximum value of the minute tens digit.
- M0_LIMIT, 4'd9, maximum value of the minute units digit.

Ports:
- clk  input  1  global clock
- rst_n  input  1  low active reset
- btn_mode  input  1  one-cycle pulse: select next digit (SET) / abort to SET (PAUSE)
- btn_inc  input  1  one-cycle pulse: increment selected digit
- btn_dec  input  1  one-cycle pulse: decrement selected digit
- btn_start  input  1  one-cycle pulse: start / pause / resume / acknowledge
- cnt_zero  input  1  counter reports all six digits at BCD zero
- init_value_h1  output  4  hour tens BCD start value
- init_value_h0  output  4  hour units BCD start value
- init_value_m1  output  4  minute tens BCD start value
- init_value_m0  output  4  minute units BCD start value
- en_start  output  2  bit1 = load/hold init values, bit0 = count enable
- sel_digit  output  2  digit being edited: 0=m0, 1=m1, 2=h0, 3=h1
- state_o  output  2  current state code, for display blinking

Behaviour:
- Interface: one clock, clk; asynchronous active-low reset, rst_n. All registers clear immediately on rst_n low, independent of clk.
- Reset values:
  - all init_value digits 4'd0, sel_digit 2'd0
  - state SET (2'd0), en_start 2'b10
- State codes: SET=0, RUN=1, PAUSE=2, DONE=3.
- en_start is registered and decoded from the next state, so it changes in the same cycle as state_o:
  - SET = 2'b10
  - RUN = 2'b01
  - PAUSE = 2'b00
  - DONE = 2'b00
- Button priority when pulses coincide: btn_start > btn_mode > btn_inc > btn_dec. Only the highest-priority pulse acts in that cycle.
- SET state:
  - btn_mode: sel_digit increments modulo 4 (3 -> 0).
  - btn_inc: selected digit increments; at its LIMIT it wraps to 0.
  - btn_dec: selected digit decrements; at 0 it wraps to its LIMIT.
  - Edit results are registered and visible on the next cycle.
  - btn_start with all four init digits nonzero-in-total (not all 0) -> RUN.
  - btn_start with all four digits 0 is ignored; stay in SET.
- RUN state:
  - cnt_zero high -> DONE. This has priority over btn_start in the same cycle.
  - btn_start -> PAUSE.
  - btn_mode, btn_inc and btn_dec are ignored.
  - init_value outputs are frozen.
- PAUSE state:
  - btn_start -> RUN.
  - btn_mode -> SET with sel_digit reset to 0; init values are retained.
  - inc/dec are ignored.
- DONE state:
  - btn_start or btn_mode -> SET with sel_digit 0; init values retained for a quick restart.
  - Otherwise hold.
- cnt_zero is sampled only in RUN; it is ignored in SET, PAUSE and DONE.
- Digit values outside 0..LIMIT cannot arise. The edit logic is saturation-free wrap arithmetic on 4-bit BCD.
- Latency: one cycle from button pulse to updated outputs; no combinational path from inputs to outputs.
- Reset asserted mid-RUN: returns to SET with digits cleared. The counter sees en_start=2'b10 asynchronously with the reset.

Decomposition:
- Constants go in the shared global include, alongside BCD_BIT_WIDTH, BCD_ZERO, BCD_FIVE and BCD_NINE:
  - state codes STATE_SET/RUN/PAUSE/DONE
  - EN_START_* encodings
- One sub-module is natural: bcd_digit_editor (4-bit register with inc/dec/wrap to a limit, load-enable). It is instantiated four times with H1/H0/M1/M0 limits.
- The FSM and sel_digit logic stay in the top.

Test Plan:
- Reset then idle: outputs all 0, en_start=2'b10, state_o=0. btn_start alone -> state stays SET (all-zero guard).
- In SET, sel_digit=1 (m1), 6 btn_inc pulses -> m1 goes 1,2,3,4,5,0. Then btn_dec at 0 -> m1=5.
- Set h1=0, h0=1, m1=3, m0=0 via mode/inc. btn_start -> next cycle en_start=2'b01, state_o=1, init values stay 4'd0/1/3/0.
- RUN: btn_start -> PAUSE (en_start=00); btn_inc ignored; btn_start -> RUN; btn_mode in PAUSE -> SET with sel_digit=0 and values kept.
- RUN with cnt_zero and btn_start asserted in the same cycle -> DONE (state_o=3, en_start=00). Then btn_start -> SET.
- Simultaneous btn_mode+btn_inc in SET -> only sel_digit advances, no digit changes. rst_n low mid-RUN -> immediate SET, digits 0.

Source files
------------

// File: rtl/timer_setting_ctrl_pkg.sv
// timer_setting_ctrl_pkg: shared BCD constants, state codes and en_start encodings
package timer_setting_ctrl_pkg;
  localparam int BCD_BIT_WIDTH = 4;
  localparam logic [BCD_BIT_WIDTH-1:0] BCD_ZERO = 4'd0;
  localparam logic [BCD_BIT_WIDTH-1:0] BCD_FIVE = 4'd5;
  localparam logic [BCD_BIT_WIDTH-1:0] BCD_NINE = 4'd9;
  typedef enum logic [1:0] {
    STATE_SET   = 2'd0,
    STATE_RUN   = 2'd1,
    STATE_PAUSE = 2'd2,
    STATE_DONE  = 2'd3
  } state_e;
  localparam logic [1:0] EN_START_SET  = 2'b10;
  localparam logic [1:0] EN_START_RUN  = 2'b01;
  localparam logic [1:0] EN_START_IDLE = 2'b00;
  function automatic logic [1:0] en_start_of(input state_e s);
    return s == STATE_SET ? EN_START_SET : s == STATE_RUN ? EN_START_RUN : EN_START_IDLE;
  endfunction
endpackage

// File: rtl/timer_setting_ctrl_bcd_digit_editor.sv
// bcd_digit_editor: one BCD digit register with wrap-around inc/dec up to LIMIT
module bcd_digit_editor
  import timer_setting_ctrl_pkg::*;
#(
  parameter logic [BCD_BIT_WIDTH-1:0] LIMIT = BCD_NINE
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     inc,
  input  logic                     dec,
  output logic [BCD_BIT_WIDTH-1:0] value_o
);
  logic [BCD_BIT_WIDTH-1:0] value_q, value_d;
  // inc wins over dec when both arrive together
  always_comb
    value_d = !en ? value_q
            : inc ? (value_q == LIMIT ? BCD_ZERO : value_q + 4'd1)
            : dec ? (value_q == BCD_ZERO ? LIMIT : value_q - 4'd1)
            : value_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) value_q <= BCD_ZERO;
    else value_q <= value_d;
  assign value_o = value_q;
endmodule

// File: rtl/timer_setting_ctrl.sv
// timer_setting_ctrl: HH:MM start-value editor and SET/RUN/PAUSE/DONE sequencer for the BCD down counter
module timer_setting_ctrl
  import timer_setting_ctrl_pkg::*;
#(
  parameter logic [BCD_BIT_WIDTH-1:0] H1_LIMIT = BCD_FIVE,
  parameter logic [BCD_BIT_WIDTH-1:0] H0_LIMIT = BCD_NINE,
  parameter logic [BCD_BIT_WIDTH-1:0] M1_LIMIT = BCD_FIVE,
  parameter logic [BCD_BIT_WIDTH-1:0] M0_LIMIT = BCD_NINE
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     btn_mode,
  input  logic                     btn_inc,
  input  logic                     btn_dec,
  input  logic                     btn_start,
  input  logic                     cnt_zero,
  output logic [BCD_BIT_WIDTH-1:0] init_value_h1,
  output logic [BCD_BIT_WIDTH-1:0] init_value_h0,
  output logic [BCD_BIT_WIDTH-1:0] init_value_m1,
  output logic [BCD_BIT_WIDTH-1:0] init_value_m0,
  output logic [1:0]               en_start,
  output logic [1:0]               sel_digit,
  output logic [1:0]               state_o
);
  state_e     state_q, state_d;
  logic [1:0] sel_q, sel_d, en_start_q, en_start_d;
  logic [3:0] dig_en;
  logic       edit, all_zero;
  // digits are edited only when neither start nor mode claims the cycle
  assign edit     = state_q == STATE_SET && !btn_start && !btn_mode;
  assign dig_en   = edit ? 4'b0001 << sel_q : 4'b0000;
  assign all_zero = ~|{init_value_h1, init_value_h0, init_value_m1, init_value_m0};
  bcd_digit_editor #(.LIMIT(M0_LIMIT)) u_m0 (.clk, .rst_n, .en(dig_en[0]), .inc(btn_inc), .dec(btn_dec), .value_o(init_value_m0));
  bcd_digit_editor #(.LIMIT(M1_LIMIT)) u_m1 (.clk, .rst_n, .en(dig_en[1]), .inc(btn_inc), .dec(btn_dec), .value_o(init_value_m1));
  bcd_digit_editor #(.LIMIT(H0_LIMIT)) u_h0 (.clk, .rst_n, .en(dig_en[2]), .inc(btn_inc), .dec(btn_dec), .value_o(init_value_h0));
  bcd_digit_editor #(.LIMIT(H1_LIMIT)) u_h1 (.clk, .rst_n, .en(dig_en[3]), .inc(btn_inc), .dec(btn_dec), .value_o(init_value_h1));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q    <= STATE_SET;
      sel_q      <= 2'd0;
      en_start_q <= EN_START_SET;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      en_start_q <= en_start_d;
    end
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    case (state_q)
      STATE_SET:
        if (btn_start) state_d = all_zero ? STATE_SET : STATE_RUN;
        else if (btn_mode) sel_d = sel_q + 2'd1;
      STATE_RUN:
        state_d = cnt_zero ? STATE_DONE : btn_start ? STATE_PAUSE : STATE_RUN;
      STATE_PAUSE:
        if (btn_start) state_d = STATE_RUN;
        else if (btn_mode) begin
          state_d = STATE_SET;
          sel_d   = 2'd0;
        end
      STATE_DONE:
        if (btn_start || btn_mode) begin
          state_d = STATE_SET;
          sel_d   = 2'd0;
        end
      default: state_d = STATE_SET;
    endcase
  end
  // registering the next-state decode keeps en_start aligned with state_o
  always_comb en_start_d = en_start_of(state_d);
  assign en_start  = en_start_q;
  assign sel_digit = sel_q;
  assign state_o   = state_q;
endmodule

// File: tb/tb_timer_setting_ctrl.sv
// tb_timer_setting_ctrl: scoreboard bench with a behavioural model of the timer controller
module tb_timer_setting_ctrl;
  logic       clk = 0, rst_n = 0;
  logic       btn_mode = 0, btn_inc = 0, btn_dec = 0, btn_start = 0, cnt_zero = 0;
  logic [3:0] h1, h0, m1, m0;
  logic [1:0] en_start, sel_digit, state_o;
  typedef struct packed {
    logic [1:0] st, en, sel;
    logic [3:0] h1, h0, m1, m0;
  } exp_t;
  exp_t sb[$];
  int   n_chk = 0, n_pass = 0;
  int   st = 0, sel = 0;
  int   dig[4] = '{0, 0, 0, 0};
  int   lim[4] = '{9, 5, 9, 5};
  timer_setting_ctrl dut (
    .clk(clk), .rst_n(rst_n), .btn_mode(btn_mode), .btn_inc(btn_inc), .btn_dec(btn_dec),
    .btn_start(btn_start), .cnt_zero(cnt_zero), .init_value_h1(h1), .init_value_h0(h0),
    .init_value_m1(m1), .init_value_m0(m0), .en_start(en_start), .sel_digit(sel_digit), .state_o(state_o)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask
  function automatic exp_t model_exp();
    exp_t e;
    e.st  = 2'(st);
    e.en  = st == 0 ? 2'b10 : st == 1 ? 2'b01 : 2'b00;
    e.sel = 2'(sel);
    e.h1  = 4'(dig[3]);
    e.h0  = 4'(dig[2]);
    e.m1  = 4'(dig[1]);
    e.m0  = 4'(dig[0]);
    return e;
  endfunction
  task automatic model_step(input bit s, m, i, d, z);
    case (st)
      0: if (s) begin
           if (dig[0] + dig[1] + dig[2] + dig[3] != 0) st = 1;
         end else if (m) sel = (sel + 1) % 4;
         else if (i) dig[sel] = dig[sel] == lim[sel] ? 0 : dig[sel] + 1;
         else if (d) dig[sel] = dig[sel] == 0 ? lim[sel] : dig[sel] - 1;
      1: if (z) st = 3; else if (s) st = 2;
      2: if (s) st = 1; else if (m) begin st = 0; sel = 0; end
      default: if (s || m) begin st = 0; sel = 0; end
    endcase
  endtask
  task automatic pop_check(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      n_chk++;
      $display("FAIL %s: scoreboard empty, got nothing expected an entry", tag);
      return;
    end
    e = sb.pop_front();
    check({tag, ".state"}, int'(state_o), int'(e.st));
    check({tag, ".en"}, int'(en_start), int'(e.en));
    check({tag, ".sel"}, int'(sel_digit), int'(e.sel));
    check({tag, ".h1"}, int'(h1), int'(e.h1));
    check({tag, ".h0"}, int'(h0), int'(e.h0));
    check({tag, ".m1"}, int'(m1), int'(e.m1));
    check({tag, ".m0"}, int'(m0), int'(e.m0));
  endtask
  task automatic step(input string tag, input bit s, m, i, d, z);
    btn_start = s; btn_mode = m; btn_inc = i; btn_dec = d; cnt_zero = z;
    model_step(s, m, i, d, z);
    sb.push_back(model_exp());
    @(negedge clk);
    pop_check(tag);
    btn_start = 0; btn_mode = 0; btn_inc = 0; btn_dec = 0; cnt_zero = 0;
  endtask
  // reset lands mid-cycle so its effect must be visible without a clock edge
  task automatic do_reset(input string tag);
    #2 rst_n = 0;
    st = 0; sel = 0;
    foreach (dig[k]) dig[k] = 0;
    sb.push_back(model_exp());
    #1 pop_check(tag);
    @(negedge clk);
    rst_n = 1;
  endtask
  initial begin
    @(negedge clk);
    do_reset("reset");
    step("idle", 0, 0, 0, 0, 0);
    step("start_zero_guard", 1, 0, 0, 0, 0);
    step("mode_sel1", 0, 1, 0, 0, 0);
    for (int k = 0; k < 6; k++) step("m1_inc", 0, 0, 1, 0, 0);
    step("m1_dec_wrap", 0, 0, 0, 1, 0);
    step("m1_dec", 0, 0, 0, 1, 0);
    step("m1_dec", 0, 0, 0, 1, 0);
    step("mode_inc_prio", 0, 1, 1, 0, 0);
    step("h0_inc", 0, 0, 1, 0, 0);
    step("mode_h1", 0, 1, 0, 0, 0);
    step("h1_dec_wrap", 0, 0, 0, 1, 0);
    step("h1_inc_wrap", 0, 0, 1, 0, 0);
    step("mode_m0", 0, 1, 0, 0, 0);
    step("m0_dec_wrap", 0, 0, 0, 1, 0);
    step("m0_incdec_prio", 0, 0, 1, 1, 0);
    step("start_run", 1, 0, 0, 0, 0);
    step("run_inc_ign", 0, 0, 1, 0, 0);
    step("run_mode_ign", 0, 1, 0, 0, 0);
    step("pause", 1, 0, 0, 0, 0);
    step("pause_inc_ign", 0, 0, 1, 0, 0);
    step("pause_zero_ign", 0, 0, 0, 0, 1);
    step("resume", 1, 0, 0, 0, 0);
    step("pause2", 1, 0, 0, 0, 0);
    step("abort_set", 0, 1, 0, 0, 0);
    step("restart", 1, 0, 0, 0, 0);
    step("zero_start_done", 1, 0, 0, 0, 1);
    step("done_hold", 0, 0, 1, 0, 1);
    step("done_ack", 1, 0, 0, 0, 0);
    step("set_zero_ign", 0, 0, 0, 0, 1);
    step("run_again", 1, 0, 0, 0, 0);
    step("run_idle", 0, 0, 0, 0, 0);
    do_reset("reset_mid_run");
    step("post_reset", 0, 0, 0, 0, 0);
    for (int k = 0; k < 300; k++)
      step("rand", $urandom_range(0, 7) == 0, $urandom_range(0, 4) == 0,
           $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
